contador_ctrl: RTL and testbench

- 8-bit synchronous up-counter used in the control unit for sequencing.
- Counts from 0 up to a programmable terminal value (counterReg), then wraps to 0.
- One clock domain. Synchronous active-high reset forces the count to 0.

---
 rtl/contador_ctrl.sv | 42 ++++
 tb/tb_contador_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/contador_ctrl.sv
// contador_ctrl: WIDTH-bit synchronous up-counter for control-unit sequencing.
// It counts 0, 1, ..., counterReg and then wraps to 0, so the period is
// counterReg+1 cycles. The terminal value is sampled on every edge and is not latched.
module contador_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,       // active-high synchronous reset
    input  logic [WIDTH-1:0] counterReg,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_terminal;

    // The wrap test uses >= so that lowering counterReg below the current count
    // sends the counter straight back to 0 instead of letting it run up to all-ones.
    always_comb begin
        count_d     = count_q;
        at_terminal = (count_q >= counterReg);
        if (at_terminal) begin
            count_d = '0;
        end else begin
            count_d = count_q + One;
        end
    end

    // Count register. Reset has priority over counting.
    always_ff @(posedge clk) begin
        if (rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out = count_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Testbench for contador_ctrl: directed steps from the test plan followed by random traffic.
// Every output is checked against a cycle-level reference model of the count sequence.
module tb_contador_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic [W-1:0] counterReg;
    logic [W-1:0] out;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;  // reference count; only meaningful after the first reset

    contador_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .counterReg (counterReg),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a reset clears the count; otherwise the count advances through
    // 0..terminal and returns to 0 once it reaches or passes the terminal value.
    function automatic int next_count(int cur, bit rst, int term);
        if (rst) return 0;
        if (cur >= term) return 0;
        return (cur + 1) % (1 << W);
    endfunction

    task automatic check(input string tag);
        logic [W-1:0] expv;
        expv = model_cnt[W-1:0];
        total++;
        assert (out === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, out, expv);
        end
    endtask

    // Apply one clock edge with the given inputs, advance the model, and check the result.
    task automatic step(input bit rst, input int term, input string tag);
        rstn       = rst;
        counterReg = term[W-1:0];
        @(posedge clk);
        model_cnt = next_count(model_cnt, rst, term);
        #1;
        check(tag);
    endtask

    initial begin
        rstn       = 1'b1;
        counterReg = 8'd10;
        @(negedge clk);

        // Reset and basic counting.
        step(1, 10, "reset");
        for (int i = 0; i < 3; i++) step(0, 10, "count");

        // Reset in the middle of a count, then resume counting from 1.
        step(1, 10, "reset_mid");
        step(0, 10, "resume");

        // Wrap at the terminal value: 1 .. 10, then 0, then 1.
        step(1, 10, "pre_wrap_reset");
        for (int i = 0; i < 12; i++) step(0, 10, "wrap");

        // Lower the terminal value below the current count.
        step(1, 10, "pre_lower_reset");
        for (int i = 0; i < 7; i++) step(0, 10, "to_seven");
        step(0, 4, "lowered");
        for (int i = 0; i < 6; i++) step(0, 4, "after_lower");

        // A terminal value of 0 keeps the count at 0.
        for (int i = 0; i < 5; i++) step(0, 0, "term_zero");

        // Full-range counting: 0 .. 255, then wrap to 0 with no overflow.
        step(1, 255, "full_reset");
        for (int i = 0; i < 257; i++) step(0, 255, "full_range");

        // Random traffic with occasional resets and changes to the terminal value.
        for (int i = 0; i < 400; i++) begin
            bit rst;
            int term;
            rst = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: term = $urandom_range(0, 3);
                1: term = $urandom_range(250, 255);
                default: term = $urandom_range(0, 40);
            endcase
            // Keep the terminal value stable over stretches so that wraps actually happen.
            if ($urandom_range(0, 7) != 0 && i > 0) term = counterReg;
            step(rst, term, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
